mm_mul256_seq: RTL and testbench

Sequential 256x256-bit multiplier controller for the modular-multiplication datapath. It feeds the pipelined 256x64 multiplier one 64-bit limb of B per cycle and consumes that multiplier's 320-bit partial products. It accumulates them, shifted by limb position, into a 512-bit full product for the downstream Montgomery reduction stage. One operation is in flight at a time.

---
 rtl/mm_mul256_seq_if.sv | 49 ++++
 rtl/mm_mul256_seq.sv | 160 ++++++++++++++++
 tb/tb_mm_mul256_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_mul256_seq_if.sv
// ---------------------------------------------------------------------------
// mm_mul256_seq_if
// Bundle between the 256x256 sequential multiplier controller, its requester
// and the attached pipelined 256x64 multiplier.
//
//   start   requester -> ctrl   request a new operation (taken when busy=0)
//   a, b    requester -> ctrl   256-bit operands, sampled at the accepting edge
//   busy    ctrl -> requester   operation in progress
//   done    ctrl -> requester   one-cycle pulse, p valid and updated
//   p       ctrl -> requester   512-bit product of the last completed op
//   mul_a   ctrl -> multiplier  256-bit operand, held for the whole op
//   mul_b   ctrl -> multiplier  64-bit limb of b, one per cycle
//   mul_p   multiplier -> ctrl  320-bit partial product mul_a*mul_b
//   op_cnt  ctrl -> requester   completed-operation counter (MM_SEQ_OPCNT_EN)
//
// Optional feature macro: MM_SEQ_OPCNT_EN adds op_cnt.
// ---------------------------------------------------------------------------
interface mm_mul256_seq_if;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;
  logic         busy;
  logic         done;
  logic [511:0] p;
  logic [255:0] mul_a;
  logic [63:0]  mul_b;
  logic [319:0] mul_p;
`ifdef MM_SEQ_OPCNT_EN
  logic [31:0]  op_cnt;
`endif

  // Controller side.
  modport slave (
    input  start, a, b, mul_p,
`ifdef MM_SEQ_OPCNT_EN
    output op_cnt,
`endif
    output busy, done, p, mul_a, mul_b
  );

  // Environment side: requester plus the attached multiplier.
  modport master (
    output start, a, b, mul_p,
`ifdef MM_SEQ_OPCNT_EN
    input  op_cnt,
`endif
    input  busy, done, p, mul_a, mul_b
  );
endinterface

// File: rtl/mm_mul256_seq.sv
// ---------------------------------------------------------------------------
// mm_mul256_seq
// Sequential 256x256 multiplier controller. Issues the four 64-bit limbs of b
// to an external pipelined 256x64 multiplier on consecutive cycles and
// accumulates the returning 320-bit partial products, shifted by limb
// position, into a 512-bit product.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mm_mul256_seq_if.slave (start/a/b/busy/done/p/mul_a/mul_b/mul_p
//        and, with MM_SEQ_OPCNT_EN, op_cnt)
//
// Parameter MUL_LAT (1..8): edges from mul_a/mul_b change to matching mul_p.
// Optional feature macro: MM_SEQ_OPCNT_EN (32-bit wrapping done counter).
// ---------------------------------------------------------------------------
module mm_mul256_seq #(
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  mm_mul256_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e       state_q, state_d;
  logic [191:0] b_hi_q, b_hi_d;       // limbs not yet issued, next one in [63:0]
  logic [511:0] acc_q, acc_d;
  logic [511:0] p_q, p_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [255:0] mul_a_q, mul_a_d;
  logic [63:0]  mul_b_q, mul_b_d;
  logic         iss_vld_q, iss_vld_d;  // a limb is on mul_b this cycle
  logic [1:0]   iss_k_q, iss_k_d;      // its limb index

  // Tag pipeline: stage MUL_LAT-1 lines up with the matching mul_p.
  logic [MUL_LAT-1:0]      tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][1:0] tag_k_q, tag_k_d;

  logic         out_vld;
  logic [1:0]   out_k;
  logic [511:0] addend;
  logic [511:0] sum;

  assign out_vld = tag_vld_q[MUL_LAT-1];
  assign out_k   = tag_k_q[MUL_LAT-1];
  // Position the partial product at bit 64*k; 64*3+320 = 512 so nothing is lost.
  assign addend  = {192'b0, bus.mul_p} << {out_k, 6'b0};
  // The true product is below 2^512, so the carry out of bit 511 never occurs.
  assign sum     = acc_q + addend;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    b_hi_d    = b_hi_q;
    acc_d     = acc_q;
    p_d       = p_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    iss_vld_d = 1'b0;
    iss_k_d   = iss_k_q;

    tag_vld_d[0] = iss_vld_q;
    tag_k_d[0]   = iss_k_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_k_d[i]   = tag_k_q[i-1];
    end

    if (out_vld) acc_d = sum;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mul_a_d   = bus.a;
          mul_b_d   = bus.b[63:0];
          b_hi_d    = bus.b[255:64];
          acc_d     = '0;
          busy_d    = 1'b1;
          iss_vld_d = 1'b1;
          iss_k_d   = 2'd0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_b_d   = b_hi_q[63:0];
        b_hi_d    = {64'b0, b_hi_q[191:64]};
        iss_vld_d = 1'b1;
        iss_k_d   = iss_k_q + 2'd1;
        if (iss_k_q == 2'd2) state_d = DRAIN;
      end
      DRAIN: begin
        // Limb 3 is the last one issued, so its arrival completes the sum.
        if (out_vld && out_k == 2'd3) begin
          p_d     = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the whole datapath, accumulator and tags included, is reset so an
    // aborted operation leaves no in-flight partial product behind.
    if (rst) begin
      state_q   <= IDLE;
      b_hi_q    <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      iss_vld_q <= 1'b0;
      iss_k_q   <= '0;
      tag_vld_q <= '0;
      tag_k_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      b_hi_q    <= b_hi_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      iss_vld_q <= iss_vld_d;
      iss_k_q   <= iss_k_d;
      tag_vld_q <= tag_vld_d;
      tag_k_q   <= tag_k_d;
    end
  end

`ifdef MM_SEQ_OPCNT_EN
  logic [31:0] op_cnt_q;

  // Wraps naturally at 2^32; start does not clear it.
  always_ff @(posedge clk) begin
    if (rst)         op_cnt_q <= '0;
    else if (done_d) op_cnt_q <= op_cnt_q + 32'd1;
  end

  assign bus.op_cnt = op_cnt_q;
`endif

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.p     = p_q;
  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;

endmodule

// File: tb/tb_mm_mul256_seq.sv
// ---------------------------------------------------------------------------
// tb_mm_mul256_seq
// Self-checking bench for mm_mul256_seq. The attached 256x64 multiplier is
// modelled as a MUL_LAT-deep delay line of products; expected results are
// the plain 512-bit product a*b of the operands.
// ---------------------------------------------------------------------------
module tb_mm_mul256_seq;
  localparam int MUL_LAT = 2;
  localparam int LAT     = 4 + MUL_LAT;  // accept edge to done edge

  logic clk = 1'b0;
  logic rst;

  mm_mul256_seq_if ifc ();

  mm_mul256_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Multiplier model: product of the values present before an edge appears
  // on mul_p MUL_LAT edges after they were driven.
  logic [319:0] hist [MUL_LAT];
  always @(posedge clk) begin
    hist[0] <= {64'b0, ifc.mul_a} * {256'b0, ifc.mul_b};
    for (int i = 1; i < MUL_LAT; i++) hist[i] <= hist[i-1];
  end
  assign ifc.mul_p = hist[MUL_LAT-1];

  int           n_pass  = 0;
  int           n_total = 0;
  int           n_done  = 0;
  logic [511:0] last_p  = '0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] full_mul(input logic [255:0] x, input logic [255:0] y);
    return {256'b0, x} * {256'b0, y};
  endfunction

  // Present an operation at the next edge (E0); returns just after E0.
  task automatic issue(input logic [255:0] opa, input logic [255:0] opb);
    ifc.start = 1'b1;
    ifc.a     = opa;
    ifc.b     = opb;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Called just after E0. Follows the op to done and checks latency, busy,
  // held mul_a, limb order on mul_b, p holding then updating, and the done
  // pulse width. poke: pulse start during the op. chain: start the next op
  // (ca, cb) in the done cycle.
  task automatic finish(input string tag, input logic [255:0] opa, input logic [255:0] opb,
                        input bit poke, input bit chain,
                        input logic [255:0] ca, input logic [255:0] cb);
    int  e       = 0;
    bit  seen    = 1'b0;
    bit  busy_ok = 1'b1;
    bit  ma_ok   = 1'b1;
    bit  mb_ok   = 1'b1;
    bit  ph_ok   = 1'b1;
    logic [511:0] exp = full_mul(opa, opb);

    if (ifc.busy !== 1'b1) busy_ok = 1'b0;
    if (ifc.mul_b !== opb[63:0]) mb_ok = 1'b0;
    if (ifc.mul_a !== opa) ma_ok = 1'b0;
    while (!seen && e < 40) begin
      @(negedge clk);
      e++;
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (ifc.busy !== 1'b1) busy_ok = 1'b0;
        if (ifc.p !== last_p) ph_ok = 1'b0;
      end
      if (ifc.mul_a !== opa) ma_ok = 1'b0;
      if (e <= 3 && ifc.mul_b !== opb[64*e +: 64]) mb_ok = 1'b0;
      ifc.start = (poke && e == 2);
      if (poke && e == 2) begin
        ifc.a = rnd256();
        ifc.b = rnd256();
      end
    end
    check({tag, " latency"}, 512'(e), 512'(LAT));
    check({tag, " busy during op"}, 512'(busy_ok), 512'd1);
    check({tag, " busy low at done"}, 512'(ifc.busy), 512'd0);
    check({tag, " mul_a held"}, 512'(ma_ok), 512'd1);
    check({tag, " mul_b limbs"}, 512'(mb_ok), 512'd1);
    check({tag, " p held"}, 512'(ph_ok), 512'd1);
    check({tag, " p"}, ifc.p, exp);
    last_p = exp;
    n_done++;
`ifdef MM_SEQ_OPCNT_EN
    check({tag, " op_cnt"}, 512'(ifc.op_cnt), 512'(n_done));
`endif
    if (chain) begin
      ifc.start = 1'b1;
      ifc.a     = ca;
      ifc.b     = cb;
    end
    @(negedge clk);
    ifc.start = 1'b0;
    check({tag, " done one cycle"}, 512'(ifc.done), 512'd0);
    if (chain) check({tag, " chained start taken"}, 512'(ifc.busy), 512'd1);
  endtask

  initial begin
    logic [255:0] ra, rb, ca, cb;
    bit           no_done;

    rst       = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    repeat (3) @(negedge clk);
    check("reset busy",  512'(ifc.busy),  512'd0);
    check("reset done",  512'(ifc.done),  512'd0);
    check("reset p",     ifc.p,           512'd0);
    check("reset mul_a", 512'(ifc.mul_a), 512'd0);
    check("reset mul_b", 512'(ifc.mul_b), 512'd0);
`ifdef MM_SEQ_OPCNT_EN
    check("reset op_cnt", 512'(ifc.op_cnt), 512'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Reset at E3 of a running op: no done, p keeps its pre-op value.
    issue(rnd256(), rnd256());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 512'(ifc.busy), 512'd0);
    no_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ifc.done !== 1'b0) no_done = 1'b0;
      @(negedge clk);
    end
    check("midrst no done", 512'(no_done), 512'd1);
    check("midrst p kept", ifc.p, last_p);

    issue(256'd3, 256'd7);
    finish("a3b7", 256'd3, 256'd7, 1'b0, 1'b0, '0, '0);
    check("a3b7 literal", ifc.p, 512'd21);

    issue(256'd1, 256'd1);
    finish("a1b1", 256'd1, 256'd1, 1'b0, 1'b0, '0, '0);
    check("a1b1 literal", ifc.p, 512'd1);

    issue('1, '1);
    finish("allones", '1, '1, 1'b0, 1'b0, '0, '0);
    check("allones literal", ifc.p, 512'd0 - (512'd1 << 257) + 512'd1);

    issue(256'd5, 256'd1 << 192);
    finish("limb3", 256'd5, 256'd1 << 192, 1'b0, 1'b0, '0, '0);
    check("limb3 literal", ifc.p, 512'd5 << 192);

    // Start pulsed mid-op is ignored; then a start in the done cycle is taken.
    ra = rnd256();
    rb = rnd256();
    ca = rnd256();
    cb = rnd256();
    issue(ra, rb);
    finish("poke", ra, rb, 1'b1, 1'b1, ca, cb);
    finish("chained", ca, cb, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 4; i++) begin
      ra = rnd256();
      rb = rnd256();
      issue(ra, rb);
      finish($sformatf("rand%0d", i), ra, rb, 1'b0, 1'b0, '0, '0);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final reset p", ifc.p, 512'd0);
`ifdef MM_SEQ_OPCNT_EN
    check("final reset op_cnt", 512'(ifc.op_cnt), 512'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
